// File: rtl/pc_exc_unit.sv
// Program counter with overflow-trap handling: RUN / EXC / HALT control, EPC/Cause capture.
// Optional trap counter on ExcCount is built only when PC_EXC_COUNT_EN is defined.
module pc_exc_unit #(
    parameter int unsigned    WL         = 32,
    parameter logic [WL-1:0]  RESET_PC   = 32'h0000_0000,
    parameter logic [WL-1:0]  EXC_VECTOR = 32'h8000_0180
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          StallIn,
    input  logic [WL-1:0] PCPlus4,
    input  logic [WL-1:0] PCBranch,
    input  logic [WL-1:0] PCJump,
    input  logic          PCSrcBr,
    input  logic          Jump,
    input  logic          OVF_F,
    input  logic          OvfTrapEn,
    input  logic          ERet,
    output logic [WL-1:0] PC,
    output logic [WL-1:0] EPC,
    output logic [4:0]    Cause,
    output logic          Flush,
    output logic          InHandler,
    output logic          Halted,
    output logic [7:0]    ExcCount
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_EXC  = 2'b01,
        ST_HALT = 2'b10
    } state_t;

    localparam logic [4:0]    CAUSE_OVF = 5'd12;
    localparam logic [WL-1:0] PC_STEP   = {{(WL-3){1'b0}}, 3'd4};

    state_t        state_q, state_d;
    logic [WL-1:0] pc_q, pc_d;
    logic [WL-1:0] epc_q, epc_d;
    logic [4:0]    cause_q, cause_d;
    logic          in_handler_q, halted_q;
    logic          t_s;
    logic [WL-1:0] seq_pc_s;

    assign t_s   = OVF_F & OvfTrapEn & ~StallIn & ~halted_q;
    assign Flush = t_s;

    // Ordinary next-PC selection when no trap or return is in effect.
    always_comb begin
        seq_pc_s = PCPlus4;
        if (Jump) begin
            seq_pc_s = PCJump;
        end else if (PCSrcBr) begin
            seq_pc_s = PCBranch;
        end else begin
            seq_pc_s = PCPlus4;
        end
    end

    // Next-state and register updates; a stall freezes everything.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
        cause_d = cause_q;
        if (StallIn) begin
            state_d = state_q;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (t_s) begin
                        epc_d   = pc_q;
                        cause_d = CAUSE_OVF;
                        pc_d    = EXC_VECTOR;
                        state_d = ST_EXC;
                    end else begin
                        pc_d = seq_pc_s;
                    end
                end
                ST_EXC: begin
                    // Overflow inside the handler is unrecoverable: freeze in HALT.
                    if (t_s) begin
                        state_d = ST_HALT;
                    end else if (ERet) begin
                        pc_d    = epc_q + PC_STEP;
                        state_d = ST_RUN;
                    end else begin
                        pc_d = seq_pc_s;
                    end
                end
                ST_HALT: begin
                    state_d = ST_HALT;
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // Architectural registers and status flags.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_RUN;
            pc_q         <= RESET_PC;
            epc_q        <= '0;
            cause_q      <= 5'd0;
            in_handler_q <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            epc_q        <= epc_d;
            cause_q      <= cause_d;
            in_handler_q <= (state_d == ST_EXC);
            halted_q     <= (state_d == ST_HALT);
        end
    end

`ifdef PC_EXC_COUNT_EN
    logic [7:0] exc_cnt_q, exc_cnt_d;
    logic       cnt_inc_s;

    assign cnt_inc_s = (state_q == ST_RUN) & t_s;

    // Saturating count of RUN->EXC entries; double faults never count.
    always_comb begin
        exc_cnt_d = exc_cnt_q;
        if (cnt_inc_s && (exc_cnt_q != 8'hFF)) begin
            exc_cnt_d = exc_cnt_q + 8'd1;
        end else begin
            exc_cnt_d = exc_cnt_q;
        end
    end

    // Trap counter register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            exc_cnt_q <= 8'h00;
        end else begin
            exc_cnt_q <= exc_cnt_d;
        end
    end

    assign ExcCount = exc_cnt_q;
`else
    assign ExcCount = 8'h00;
`endif

    assign PC        = pc_q;
    assign EPC       = epc_q;
    assign Cause     = cause_q;
    assign InHandler = in_handler_q;
    assign Halted    = halted_q;

endmodule

// File: tb/tb_pc_exc_unit.sv
// Randomized self-checking bench for pc_exc_unit against a behavioural trap/PC model.
module tb_pc_exc_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] VEC    = 32'h8000_0180;

    logic        CLK = 1'b0;
    logic        RST, StallIn, PCSrcBr, Jump, OVF_F, OvfTrapEn, ERet;
    logic [31:0] PCPlus4, PCBranch, PCJump;
    logic [31:0] PC, EPC;
    logic [4:0]  Cause;
    logic        Flush, InHandler, Halted;
    logic [7:0]  ExcCount;

    int chk_cnt  = 0;
    int fail_cnt = 0;

    // Reference model: mode 0 = running, 1 = in handler, 2 = halted.
    int          m_mode;
    logic [31:0] m_pc, m_epc;
    logic [4:0]  m_cause;
    int          m_cnt;

    pc_exc_unit #(.WL(32), .RESET_PC(RST_PC), .EXC_VECTOR(VEC)) dut (
        .CLK(CLK), .RST(RST), .StallIn(StallIn), .PCPlus4(PCPlus4),
        .PCBranch(PCBranch), .PCJump(PCJump), .PCSrcBr(PCSrcBr), .Jump(Jump),
        .OVF_F(OVF_F), .OvfTrapEn(OvfTrapEn), .ERet(ERet), .PC(PC), .EPC(EPC),
        .Cause(Cause), .Flush(Flush), .InHandler(InHandler), .Halted(Halted),
        .ExcCount(ExcCount)
    );

    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Apply one cycle of inputs, check Flush mid-cycle and all registers after the edge.
    task automatic cyc(input logic rst, input logic stall, input logic [31:0] p4,
                       input logic [31:0] pb, input logic [31:0] pj, input logic br,
                       input logic jmp, input logic ovf, input logic en, input logic eret);
        logic trap;
        @(negedge CLK);
        RST = rst; StallIn = stall; PCPlus4 = p4; PCBranch = pb; PCJump = pj;
        PCSrcBr = br; Jump = jmp; OVF_F = ovf; OvfTrapEn = en; ERet = eret;
        trap = ovf & en & ~stall & (m_mode != 2);
        #1;
        check_val("flush", {31'd0, Flush}, {31'd0, trap});
        if (rst) begin
            m_mode = 0; m_pc = RST_PC; m_epc = 32'd0; m_cause = 5'd0; m_cnt = 0;
        end else if (stall || m_mode == 2) begin
            m_mode = m_mode;
        end else if (trap && m_mode == 0) begin
            m_epc = m_pc; m_cause = 5'd12; m_pc = VEC; m_mode = 1;
            if (m_cnt < 255) m_cnt = m_cnt + 1;
        end else if (trap) begin
            m_mode = 2;
        end else if (m_mode == 1 && eret) begin
            m_pc = m_epc + 32'd4; m_mode = 0;
        end else begin
            m_pc = jmp ? pj : (br ? pb : p4);
        end
        @(posedge CLK);
        #1;
        check_val("pc", PC, m_pc);
        check_val("epc", EPC, m_epc);
        check_val("cause", {27'd0, Cause}, {27'd0, m_cause});
        check_val("inhandler", {31'd0, InHandler}, (m_mode == 1) ? 32'd1 : 32'd0);
        check_val("halted", {31'd0, Halted}, (m_mode == 2) ? 32'd1 : 32'd0);
`ifdef PC_EXC_COUNT_EN
        check_val("exccount", {24'd0, ExcCount}, m_cnt);
`else
        check_val("exccount", {24'd0, ExcCount}, 32'd0);
`endif
    endtask

    task automatic seq(input logic rst);
        cyc(rst, 1'b0, m_pc + 32'd4, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        m_mode = 0; m_pc = 32'd0; m_epc = 32'd0; m_cause = 5'd0; m_cnt = 0;
        // Reset and straight-line fetch.
        seq(1'b1);
        check_val("reset_pc", PC, 32'h0);
        for (int i = 0; i < 3; i++) seq(1'b0);
        check_val("seq_pc_c", PC, 32'hC);
        // Jump to 0x40, then overflow trap.
        cyc(1'b0, 1'b0, m_pc + 32'd4, 32'h100, 32'h40, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, m_pc + 32'd4, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check_val("trap_pc", PC, VEC);
        check_val("trap_epc", EPC, 32'h40);
        // Return from handler, then overflow without trap enable.
        cyc(1'b0, 1'b0, m_pc + 32'd4, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_val("eret_pc", PC, 32'h44);
        cyc(1'b0, 1'b0, 32'h48, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check_val("no_trap_pc", PC, 32'h48);
        // Double fault: halt and freeze for 10 cycles, then reset.
        cyc(1'b0, 1'b0, m_pc + 32'd4, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, m_pc + 32'd4, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check_val("halted_dir", {31'd0, Halted}, 32'd1);
        for (int i = 0; i < 10; i++)
            cyc(1'b0, 1'b0, $urandom, $urandom, $urandom, 1'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom), 1'($urandom));
        check_val("halt_freeze", PC, VEC);
        seq(1'b1);
        check_val("halt_reset", {31'd0, Halted}, 32'd0);
        // Stall beats trap and jump; jump beats branch.
        cyc(1'b0, 1'b1, 32'h4, 32'h200, 32'h300, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 32'h4, 32'h200, 32'h300, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check_val("jump_prio", PC, 32'h300);
        // 256 trap/return pairs to reach counter saturation.
        for (int i = 0; i < 256; i++) begin
            cyc(1'b0, 1'b0, m_pc + 32'd4, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            cyc(1'b0, 1'b0, m_pc + 32'd4, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
`ifdef PC_EXC_COUNT_EN
        check_val("cnt_sat", {24'd0, ExcCount}, 32'hFF);
`else
        check_val("cnt_off", {24'd0, ExcCount}, 32'h0);
`endif
        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            logic ovf_en;
            ovf_en = ($urandom_range(0, 3) == 0);
            cyc(($urandom_range(0, 99) < 2), ($urandom_range(0, 4) == 0),
                ($urandom_range(0, 9) == 0) ? $urandom : m_pc + 32'd4,
                $urandom, $urandom, 1'($urandom), ($urandom_range(0, 3) == 0),
                ovf_en | ($urandom_range(0, 3) == 0), ovf_en | ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 2) == 0));
        end
        $display("TB_RESULT checks=%0d failures=%0d", chk_cnt, fail_cnt);
        $finish;
    end

endmodule
